fasu_post_norm: RTL and testbench
=================================

// Module: fasu_post_norm
// PURPOSE
//  Downstream of the add/sub pre-normalizer and 27-bit fraction adder in the FP add/sub path.
//  Takes the raw 28-bit fraction sum (carry + 27-bit aligned fraction with guard/round/sticky),
//  the large exponent and the sign, then normalizes, rounds (IEEE-754 single, 4 modes) and
//  packs a 32-bit result with flags. Two-stage elastic pipeline with valid/ready handshake.
// PARAMETERS
//  (none; fixed IEEE-754 single precision, 27-bit fraction format from pre-normalizer)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   input beat valid
//  in_ready     out  1   block accepts beat this cycle (transfer = in_valid & in_ready)
//  fract_in     in   28  [27]=carry, [26]=hidden bit, [25:3]=mantissa, [2]=G, [1]=R, [0]=S
//  exp_in       in   8   large exponent from pre-normalizer (0 = denormal, treated as 1)
//  sign_in      in   1   result sign for nonzero result
//  zero_sign    in   1   sign to use when fraction sum is exactly zero
//  rmode        in   2   0=nearest-even, 1=toward zero, 2=toward +inf, 3=toward -inf
//  nan_in       in   1   operand NaN detected upstream
//  nan_sign     in   1   sign for NaN result
//  inf_in       in   1   operand infinity (non-NaN) detected upstream; uses sign_in
//  out_valid    out  1   result valid
//  out_ready    in   1   consumer accepts result
//  result       out  32  packed IEEE single
//  ovf          out  1   overflow (result rounded to inf/max-finite from finite inputs)
//  unf          out  1   result denormal or zero and inexact
//  inexact      out  1   any of G/R/S nonzero after final shift
//  zero         out  1   result magnitude is zero
// BEHAVIOUR
//  Reset: s1/s2 valid=0, out_valid=0, result=0, ovf=unf=inexact=zero=0; in_ready=1 once out of reset.
//  Handshake: s2_adv = !out_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv.
//   Stalled stages hold all data. Latency 2 cycles accept->out_valid when unstalled; throughput 1/clk.
//   out_valid/result stay stable while out_valid & !out_ready.
//  Stage 1 (normalize), registered:
//   fract_in==0: zero path, exp=0, sign=zero_sign.
//   carry=1: fract>>1, new S = S|bit0, exp=exp_in+1 (9-bit).
//   else lz = leading zeros of fract_in[26:0] (0..26):
//    exp_in==0 -> no shift, exp=0; exp_in>lz -> shl lz, exp=exp_in-lz;
//    else -> shl exp_in-1, exp=0 (denormal result).
//  Stage 2 (round/pack), registered into outputs:
//   lsb=f[3], G=f[2], RS=f[1]|f[0]; inc: rmode0 G&(RS|lsb); rmode1 0; rmode2 !sign&(G|RS); rmode3 sign&(G|RS).
//   mant24={f[26:3]}+inc; if carry out -> mant>>1, exp+1; denormal with f[26] set after round -> exp=1.
//   exp>=255: ovf=1; rmode0, or rmode2&!sign, or rmode3&sign -> inf (exp 255, mant 0) else 0x7F7FFFFF|sign<<31.
//   Priority: nan_in -> {nan_sign,0x7FC00000[30:0]}, flags 0; then inf_in -> {sign_in,0x7F800000[30:0]}, flags 0;
//   then zero path -> {zero_sign,31'b0}, zero=1; then normal/denormal pack.
//  inexact = G|R|S at stage 2; unf = inexact & exp==0 after rounding.
//  Reset mid-operation: all in-flight beats dropped, outputs return to reset values immediately.
// TESTING
//  1) fract_in=28'h8000000, exp_in=127, sign 0, rmode0 -> 2 cycles later result=0x40000000, flags 0.
//  2) fract_in=28'h0000008, exp_in=127 (cancellation) -> result=0x34000000, inexact=0.
//  3) fract_in=28'h400000C, exp_in=127: rmode0 -> 0x3F800002 inexact=1; rmode1 -> 0x3F800001.
//  4) fract_in=28'h8000000, exp_in=254: rmode0 -> 0x7F800000 ovf=1; rmode1 -> 0x7F7FFFFF ovf=1.
//  5) fract_in=0, zero_sign=1 -> 0x80000000 zero=1; nan_in=1,nan_sign=0 -> 0x7FC00000 overriding all.
//  6) out_ready=0 for 5 clks while 3 beats offered -> in_ready low after 2 accepted; all 3 delivered
//     in order, none lost/duplicated; rst_n pulse mid-stream -> out_valid=0 same cycle.

Source files
------------

// File: rtl/fasu_post_norm.sv
// Post-normalizer for the single-precision add/sub path: normalizes the raw fraction sum,
// rounds in one of four IEEE modes and packs the result with flags, behind a 2-stage valid/ready pipe.
module fasu_post_norm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [27:0] fract_in,
    input  logic [7:0]  exp_in,
    input  logic        sign_in,
    input  logic        zero_sign,
    input  logic [1:0]  rmode,
    input  logic        nan_in,
    input  logic        nan_sign,
    input  logic        inf_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        ovf,
    output logic        unf,
    output logic        inexact,
    output logic        zero
);

    typedef enum logic [1:0] {
        RM_NEAREST = 2'd0,
        RM_ZERO    = 2'd1,
        RM_POS     = 2'd2,
        RM_NEG     = 2'd3
    } rmode_e;

    logic s1_adv, s2_adv;

    // Stage 1 state
    logic        s1_valid;
    logic [26:0] s1_fract;
    logic [8:0]  s1_exp;
    logic        s1_sign, s1_zero, s1_zero_sign, s1_nan, s1_nan_sign, s1_inf;
    logic [1:0]  s1_rmode;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // ---------------- Stage 1: normalize ----------------
    logic [4:0]  lz;
    logic [26:0] n_fract;
    logic [8:0]  n_exp;
    logic        n_zero;

    always_comb begin
        // Ascending scan: the last hit is the most significant set bit.
        lz = 5'd0;
        for (int i = 0; i <= 26; i++) begin
            if (fract_in[i]) lz = 5'(26 - i);
        end

        n_zero  = (fract_in == 28'd0);
        n_fract = fract_in[26:0];
        n_exp   = {1'b0, exp_in};
        if (n_zero) begin
            n_exp = 9'd0;
        end else if (fract_in[27]) begin
            n_fract = {fract_in[27:2], fract_in[1] | fract_in[0]};
            n_exp   = {1'b0, exp_in} + 9'd1;
        end else if (exp_in == 8'd0) begin
            n_exp = 9'd0;
        end else if (exp_in > {3'b000, lz}) begin
            n_fract = fract_in[26:0] << lz;
            n_exp   = {1'b0, exp_in} - {4'b0000, lz};
        end else begin
            // Not enough exponent range to fully normalize: result is denormal.
            n_fract = fract_in[26:0] << (exp_in - 8'd1);
            n_exp   = 9'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_fract     <= '0;
            s1_exp       <= '0;
            s1_sign      <= 1'b0;
            s1_zero      <= 1'b0;
            s1_zero_sign <= 1'b0;
            s1_nan       <= 1'b0;
            s1_nan_sign  <= 1'b0;
            s1_inf       <= 1'b0;
            s1_rmode     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_fract     <= n_fract;
                s1_exp       <= n_exp;
                s1_sign      <= sign_in;
                s1_zero      <= n_zero;
                s1_zero_sign <= zero_sign;
                s1_nan       <= nan_in;
                s1_nan_sign  <= nan_sign;
                s1_inf       <= inf_in;
                s1_rmode     <= rmode;
            end
        end
    end

    // ---------------- Stage 2: round and pack ----------------
    logic        g, rs, inc, to_inf, rnd_inexact;
    logic [24:0] sum;
    logic [23:0] mant;
    logic [8:0]  r_exp;
    logic [31:0] nx_result;
    logic        nx_ovf, nx_unf, nx_inexact, nx_zero;

    always_comb begin
        g  = s1_fract[2];
        rs = s1_fract[1] | s1_fract[0];
        case (rmode_e'(s1_rmode))
            RM_NEAREST: inc = g & (rs | s1_fract[3]);
            RM_ZERO:    inc = 1'b0;
            RM_POS:     inc = !s1_sign & (g | rs);
            default:    inc = s1_sign & (g | rs);
        endcase

        sum   = {1'b0, s1_fract[26:3]} + {24'd0, inc};
        mant  = sum[23:0];
        r_exp = s1_exp;
        if (sum[24]) begin
            mant  = sum[24:1];
            r_exp = s1_exp + 9'd1;
        end
        // A denormal that rounds up into the hidden bit becomes the smallest normal.
        if (r_exp == 9'd0 && mant[23]) r_exp = 9'd1;

        rnd_inexact = g | rs;
        to_inf = (rmode_e'(s1_rmode) == RM_NEAREST) ||
                 (rmode_e'(s1_rmode) == RM_POS && !s1_sign) ||
                 (rmode_e'(s1_rmode) == RM_NEG && s1_sign);

        nx_result  = '0;
        nx_ovf     = 1'b0;
        nx_unf     = 1'b0;
        nx_inexact = 1'b0;
        nx_zero    = 1'b0;
        if (s1_nan) begin
            nx_result = {s1_nan_sign, 31'h7FC0_0000};
        end else if (s1_inf) begin
            nx_result = {s1_sign, 31'h7F80_0000};
        end else if (s1_zero) begin
            nx_result = {s1_zero_sign, 31'd0};
            nx_zero   = 1'b1;
        end else if (r_exp >= 9'd255) begin
            nx_result  = to_inf ? {s1_sign, 31'h7F80_0000} : {s1_sign, 31'h7F7F_FFFF};
            nx_ovf     = 1'b1;
            nx_inexact = rnd_inexact;
        end else begin
            nx_result  = {s1_sign, r_exp[7:0], mant[22:0]};
            nx_inexact = rnd_inexact;
            nx_unf     = rnd_inexact && (r_exp == 9'd0);
            nx_zero    = (r_exp == 9'd0) && (mant[22:0] == 23'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            inexact   <= 1'b0;
            zero      <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result  <= nx_result;
                ovf     <= nx_ovf;
                unf     <= nx_unf;
                inexact <= nx_inexact;
                zero    <= nx_zero;
            end
        end
    end

endmodule

// File: tb/tb_fasu_post_norm.sv
// Bench for fasu_post_norm: directed vector table, stall/reset sequences and a randomized
// stream scored against an arithmetic reference model.
module tb_fasu_post_norm;

    typedef struct packed {
        logic [27:0] fract;
        logic [7:0]  exp;
        logic        sign;
        logic        zero_sign;
        logic [1:0]  rmode;
        logic        nan;
        logic        nan_sign;
        logic        inf;
    } beat_t;

    typedef struct packed {
        beat_t       b;
        logic [31:0] res;
        logic [3:0]  flags;   // {ovf, unf, inexact, zero}
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [27:0] fract_in = '0;
    logic [7:0]  exp_in = '0;
    logic        sign_in = 1'b0;
    logic        zero_sign = 1'b0;
    logic [1:0]  rmode = '0;
    logic        nan_in = 1'b0;
    logic        nan_sign = 1'b0;
    logic        inf_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        ovf, unf, inexact, zero;

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    int delivered = 0;
    logic [35:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic [35:0] held = '0;
    vec_t        vecs[20];

    fasu_post_norm dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fract_in(fract_in), .exp_in(exp_in), .sign_in(sign_in), .zero_sign(zero_sign),
        .rmode(rmode), .nan_in(nan_in), .nan_sign(nan_sign), .inf_in(inf_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .ovf(ovf), .unf(unf), .inexact(inexact), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [35:0] dut_out();
        return {result, ovf, unf, inexact, zero};
    endfunction

    function automatic beat_t mkb(input logic [27:0] f, input int e, input logic s, input logic zs,
                                  input logic [1:0] rm, input logic n, input logic ns, input logic i);
        beat_t b;
        b.fract = f; b.exp = 8'(e); b.sign = s; b.zero_sign = zs;
        b.rmode = rm; b.nan = n; b.nan_sign = ns; b.inf = i;
        return b;
    endfunction

    // Reference: value-level normalize/round using integer arithmetic.
    function automatic logic [35:0] ref_model(input beat_t b);
        longint f, kept, q;
        int e, rem;
        bit up, to_inf, ix;
        logic [31:0] r;
        if (b.nan) return {b.nan_sign, 31'h7FC0_0000, 4'b0000};
        if (b.inf) return {b.sign, 31'h7F80_0000, 4'b0000};
        if (b.fract == 28'd0) return {b.zero_sign, 31'd0, 4'b0001};
        f = longint'(b.fract);
        e = int'(b.exp);
        if (f >= 134217728) begin
            q = f / 2;
            if (f % 2 == 1 && q % 2 == 0) q = q + 1;
            f = q;
            e = e + 1;
        end else if (e != 0) begin
            while (f < 67108864 && e > 1) begin
                f = f * 2;
                e = e - 1;
            end
            if (f < 67108864) e = 0;
        end
        kept = f / 8;
        rem  = int'(f % 8);
        case (b.rmode)
            2'd0:    up = (rem > 4) || (rem == 4 && kept % 2 == 1);
            2'd1:    up = 1'b0;
            2'd2:    up = !b.sign && rem != 0;
            default: up = b.sign && rem != 0;
        endcase
        kept = kept + longint'(up);
        if (kept >= 16777216) begin
            kept = kept / 2;
            e = e + 1;
        end
        if (e == 0 && kept >= 8388608) e = 1;
        ix = (rem != 0);
        if (e >= 255) begin
            to_inf = (b.rmode == 2'd0) || (b.rmode == 2'd2 && !b.sign) || (b.rmode == 2'd3 && b.sign);
            r = to_inf ? 32'h7F80_0000 : 32'h7F7F_FFFF;
            r[31] = b.sign;
            return {r, 1'b1, 1'b0, ix, 1'b0};
        end
        r = {b.sign, 8'(e), 23'(kept % 8388608)};
        return {r, 1'b0, 1'(ix && e == 0), ix, 1'(r[30:0] == 31'd0)};
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.fract = 28'($urandom);
        case ($urandom_range(0, 9))
            0:       b.fract = 28'd0;
            1:       b.fract = 28'($urandom_range(0, 255));
            2:       b.fract[27] = 1'b1;
            3, 4:    b.fract = b.fract >> $urandom_range(0, 27);
            default: b.fract[27] = 1'b0;
        endcase
        case ($urandom_range(0, 3))
            0:       b.exp = 8'($urandom_range(0, 4));
            1:       b.exp = 8'($urandom_range(250, 255));
            default: b.exp = 8'($urandom);
        endcase
        b.sign      = 1'($urandom);
        b.zero_sign = 1'($urandom);
        b.rmode     = 2'($urandom);
        b.nan       = ($urandom_range(0, 19) == 0);
        b.nan_sign  = 1'($urandom);
        b.inf       = ($urandom_range(0, 19) == 0);
        return b;
    endfunction

    task automatic drive(input beat_t b);
        fract_in = b.fract; exp_in = b.exp; sign_in = b.sign; zero_sign = b.zero_sign;
        rmode = b.rmode; nan_in = b.nan; nan_sign = b.nan_sign; inf_in = b.inf;
    endtask

    // One clock of streaming traffic, scored against the model queue.
    task automatic step(input beat_t b, input logic v, input logic ordy);
        @(negedge clk);
        drive(b);
        in_valid = v;
        out_ready = ordy;
        #1;
        if (stall_prev) begin
            check("hold_valid", {35'd0, out_valid}, 36'd1);
            check("hold_data", dut_out(), held);
        end
        if (v && in_ready) begin
            exp_q.push_back(ref_model(b));
            accepted++;
        end
        if (out_valid && ordy) begin
            check("out_has_expected", {35'd0, exp_q.size() != 0}, 36'd1);
            if (exp_q.size() != 0) check("stream", dut_out(), exp_q.pop_front());
            delivered++;
        end
        stall_prev = out_valid && !ordy;
        held = dut_out();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        stall_prev = 1'b0;
        accepted = 0;
        delivered = 0;
    endtask

    task automatic run_vec(input int i);
        int n;
        @(negedge clk);
        drive(vecs[i].b);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check($sformatf("vec%0d_in_ready", i), {35'd0, in_ready}, 36'd1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("vec%0d_latency", i), 36'(n), 36'd1);
        check($sformatf("vec%0d_result", i), {4'd0, result}, {4'd0, vecs[i].res});
        check($sformatf("vec%0d_flags", i), {32'd0, ovf, unf, inexact, zero}, {32'd0, vecs[i].flags});
    endtask

    beat_t seq3[3];
    beat_t idle;

    initial begin
        vecs[0]  = '{b: mkb(28'h8000000, 127, 0, 0, 0, 0, 0, 0), res: 32'h40000000, flags: 4'b0000};
        vecs[1]  = '{b: mkb(28'h0000008, 127, 0, 0, 0, 0, 0, 0), res: 32'h34000000, flags: 4'b0000};
        vecs[2]  = '{b: mkb(28'h400000C, 127, 0, 0, 0, 0, 0, 0), res: 32'h3F800002, flags: 4'b0010};
        vecs[3]  = '{b: mkb(28'h400000C, 127, 0, 0, 1, 0, 0, 0), res: 32'h3F800001, flags: 4'b0010};
        vecs[4]  = '{b: mkb(28'h8000000, 254, 0, 0, 0, 0, 0, 0), res: 32'h7F800000, flags: 4'b1000};
        vecs[5]  = '{b: mkb(28'h8000000, 254, 0, 0, 1, 0, 0, 0), res: 32'h7F7FFFFF, flags: 4'b1000};
        vecs[6]  = '{b: mkb(28'h0000000, 127, 0, 1, 0, 0, 0, 0), res: 32'h80000000, flags: 4'b0001};
        vecs[7]  = '{b: mkb(28'h400000C, 127, 1, 1, 0, 1, 0, 1), res: 32'h7FC00000, flags: 4'b0000};
        vecs[8]  = '{b: mkb(28'h400000C, 127, 1, 0, 0, 0, 0, 1), res: 32'hFF800000, flags: 4'b0000};
        vecs[9]  = '{b: mkb(28'h4000001, 127, 0, 0, 2, 0, 0, 0), res: 32'h3F800001, flags: 4'b0010};
        vecs[10] = '{b: mkb(28'h4000001, 127, 1, 0, 3, 0, 0, 0), res: 32'hBF800001, flags: 4'b0010};
        vecs[11] = '{b: mkb(28'h4000001, 127, 1, 0, 2, 0, 0, 0), res: 32'hBF800000, flags: 4'b0010};
        vecs[12] = '{b: mkb(28'h0000010,   3, 0, 0, 0, 0, 0, 0), res: 32'h00000008, flags: 4'b0000};
        vecs[13] = '{b: mkb(28'h000000C,   1, 0, 0, 0, 0, 0, 0), res: 32'h00000002, flags: 4'b0110};
        vecs[14] = '{b: mkb(28'h7FFFFFC,   0, 0, 0, 0, 0, 0, 0), res: 32'h00800000, flags: 4'b0010};
        vecs[15] = '{b: mkb(28'h3FFFFFC,   1, 0, 0, 0, 0, 0, 0), res: 32'h00800000, flags: 4'b0010};
        vecs[16] = '{b: mkb(28'h4000000, 255, 0, 0, 3, 0, 0, 0), res: 32'h7F7FFFFF, flags: 4'b1000};
        vecs[17] = '{b: mkb(28'h7FFFFFF, 254, 0, 0, 0, 0, 0, 0), res: 32'h7F800000, flags: 4'b1010};
        vecs[18] = '{b: mkb(28'h0000000,  10, 0, 0, 3, 0, 0, 0), res: 32'h00000000, flags: 4'b0001};
        vecs[19] = '{b: mkb(28'h0000004,   0, 0, 0, 0, 0, 0, 0), res: 32'h00000000, flags: 4'b0111};
        idle = mkb(28'd0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        reset_dut();
        #1;
        check("reset_handshake", {34'd0, out_valid, in_ready}, 36'd1);
        check("reset_outputs", dut_out(), 36'd0);

        // Directed vectors, one beat at a time
        for (int i = 0; i < 20; i++) run_vec(i);

        // Output stall while three beats are offered
        reset_dut();
        seq3[0] = vecs[0].b;
        seq3[1] = vecs[2].b;
        seq3[2] = vecs[9].b;
        for (int c = 0; c < 5; c++) step(seq3[accepted < 3 ? accepted : 0], accepted < 3, 1'b0);
        check("stall_accepted", 36'(accepted), 36'd2);
        check("stall_in_ready", {35'd0, in_ready}, 36'd0);
        for (int c = 0; c < 20 && delivered < 3; c++)
            step(seq3[accepted < 3 ? accepted : 0], accepted < 3, 1'b1);
        check("stall_delivered", 36'(delivered), 36'd3);
        check("stall_queue_empty", 36'(exp_q.size()), 36'd0);

        // Asynchronous reset with beats in flight
        step(vecs[1].b, 1'b1, 1'b0);
        step(vecs[3].b, 1'b1, 1'b0);
        step(idle, 1'b0, 1'b0);
        check("pre_reset_valid", {35'd0, out_valid}, 36'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_handshake", {34'd0, out_valid, in_ready}, 36'd1);
        check("rst_async_outputs", dut_out(), 36'd0);
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        delivered = 0;
        step(vecs[13].b, 1'b1, 1'b1);
        for (int c = 0; c < 10 && delivered < 1; c++) step(idle, 1'b0, 1'b1);
        check("post_reset_delivered", 36'(delivered), 36'd1);

        // Randomized stream with random back-pressure
        for (int c = 0; c < 800; c++)
            step(rand_beat(), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(idle, 1'b0, 1'b1);
        check("drain_empty", 36'(exp_q.size()), 36'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
